// File: rtl/uart_mem_loader.sv
// Purpose : byte-command loader ('W','R','H','G') driving the external memory port and run/sel_uart.
// Latency : w_en one cycle after the 4th data byte; r_data captured the cycle after r_en; ACK one cycle after state entry.
// Backpressure: each TX byte waits for tx_busy low, then for a full tx_busy high->low handshake.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   rx_data, rx_done      received byte and its one-cycle strobe
//   tx_busy               transmitter busy
//   tx_start, tx_data     transmit request strobe and byte (held until tx_busy falls)
//   sel_uart, run         memory ownership select, processor run enable
//   w_adress, w_data      external port word address / write data
//   w_en, r_en            one-cycle write / read strobes
//   r_data                read data, valid the cycle after r_en
module uart_mem_loader #(
    parameter int unsigned ADDR_STEP      = 1,
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
    parameter logic [7:0]  ACK_BYTE       = 8'h06,
    parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        sel_uart,
    output logic        run,
    output logic [31:0] w_adress,
    output logic [31:0] w_data,
    output logic        w_en,
    output logic        r_en,
    input  logic [31:0] r_data
);

    localparam logic [7:0]  CMD_WRITE = 8'h57;
    localparam logic [7:0]  CMD_READ  = 8'h52;
    localparam logic [7:0]  CMD_HALT  = 8'h48;
    localparam logic [7:0]  CMD_GO    = 8'h47;
    localparam logic [31:0] STEP      = 32'(ADDR_STEP);
    // idle_cnt value on the last permitted silent cycle
    localparam logic [31:0] IDLE_LAST = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_WRITE,
        S_RD_REQ,
        S_RD_CAP,
        S_TX,
        S_TX_HI,
        S_TX_LO,
        S_ACK,
        S_NAK
    } state_t;

    state_t      state;
    logic        is_read;       // current command is 'R'
    logic [2:0]  byte_cnt;      // header byte index 0..7, data byte index 0..3
    logic [31:0] idle_cnt;      // silent cycles since the last rx_done
    logic [31:0] addr_cur;      // address of the next word
    logic [31:0] word_total;    // N from the count field
    logic [31:0] word_cnt;      // words completed so far
    logic [23:0] data_shift;    // first three bytes of the word being assembled
    logic [31:0] tx_shift;      // bytes still to send, LSB first
    logic [1:0]  tx_left;       // bytes remaining after the one in flight
    logic        tx_from_read;  // after the last byte, continue the read loop
    logic        cap_wait;      // first RD_CAP cycle is the r_en cycle itself

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            is_read      <= 1'b0;
            byte_cnt     <= '0;
            idle_cnt     <= '0;
            addr_cur     <= '0;
            word_total   <= '0;
            word_cnt     <= '0;
            data_shift   <= '0;
            tx_shift     <= '0;
            tx_left      <= '0;
            tx_from_read <= 1'b0;
            cap_wait     <= 1'b0;
            tx_start     <= 1'b0;
            tx_data      <= '0;
            sel_uart     <= 1'b1;
            run          <= 1'b0;
            w_adress     <= '0;
            w_data       <= '0;
            w_en         <= 1'b0;
            r_en         <= 1'b0;
        end else begin
            // strobes are single-cycle unless re-asserted below
            w_en     <= 1'b0;
            r_en     <= 1'b0;
            tx_start <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (rx_done) begin
                        byte_cnt <= '0;
                        idle_cnt <= '0;
                        word_cnt <= '0;
                        case (rx_data)
                            CMD_WRITE: begin
                                is_read <= 1'b0;
                                state   <= S_HDR;
                            end
                            CMD_READ: begin
                                is_read <= 1'b1;
                                state   <= S_HDR;
                            end
                            CMD_HALT: begin
                                run      <= 1'b0;
                                sel_uart <= 1'b1;
                                state    <= S_ACK;
                            end
                            CMD_GO: begin
                                sel_uart <= 1'b0;
                                run      <= 1'b1;
                                state    <= S_ACK;
                            end
                            default: state <= S_NAK;
                        endcase
                    end
                end

                S_HDR: begin
                    if (rx_done) begin
                        idle_cnt <= '0;
                        byte_cnt <= byte_cnt + 3'd1;
                        if (!byte_cnt[2]) begin
                            addr_cur[8*byte_cnt[1:0] +: 8] <= rx_data;
                        end else begin
                            word_total[8*byte_cnt[1:0] +: 8] <= rx_data;
                        end
                        if (byte_cnt == 3'd7) begin
                            byte_cnt <= '0;
                            if ({rx_data, word_total[23:0]} == 32'd0) begin
                                state <= S_ACK;
                            end else if (is_read) begin
                                state <= S_RD_REQ;
                            end else begin
                                state <= S_DATA;
                            end
                        end
                    end else if (idle_cnt == IDLE_LAST) begin
                        state <= S_NAK;
                    end else begin
                        idle_cnt <= idle_cnt + 32'd1;
                    end
                end

                S_DATA: begin
                    if (rx_done) begin
                        idle_cnt   <= '0;
                        byte_cnt   <= byte_cnt + 3'd1;
                        data_shift <= {rx_data, data_shift[23:8]};
                        if (byte_cnt == 3'd3) begin
                            byte_cnt <= '0;
                            w_adress <= addr_cur;
                            w_data   <= {rx_data, data_shift};
                            w_en     <= 1'b1;
                            state    <= S_WRITE;
                        end
                    end else if (idle_cnt == IDLE_LAST) begin
                        // partial word is simply abandoned in data_shift
                        state <= S_NAK;
                    end else begin
                        idle_cnt <= idle_cnt + 32'd1;
                    end
                end

                S_WRITE: begin
                    addr_cur <= addr_cur + STEP;
                    word_cnt <= word_cnt + 32'd1;
                    idle_cnt <= '0;
                    if (word_cnt + 32'd1 == word_total) begin
                        state <= S_ACK;
                    end else begin
                        state <= S_DATA;
                    end
                end

                S_RD_REQ: begin
                    w_adress <= addr_cur;
                    r_en     <= 1'b1;
                    cap_wait <= 1'b0;
                    state    <= S_RD_CAP;
                end

                S_RD_CAP: begin
                    if (!cap_wait) begin
                        cap_wait <= 1'b1;
                    end else begin
                        tx_shift     <= r_data;
                        tx_left      <= 2'd3;
                        tx_from_read <= 1'b1;
                        addr_cur     <= addr_cur + STEP;
                        word_cnt     <= word_cnt + 32'd1;
                        state        <= S_TX;
                    end
                end

                S_TX: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= tx_shift[7:0];
                        tx_shift <= {8'h00, tx_shift[31:8]};
                        state    <= S_TX_HI;
                    end
                end

                S_TX_HI: begin
                    if (tx_busy) begin
                        state <= S_TX_LO;
                    end
                end

                S_TX_LO: begin
                    if (!tx_busy) begin
                        if (tx_left != 2'd0) begin
                            tx_left <= tx_left - 2'd1;
                            state   <= S_TX;
                        end else if (tx_from_read) begin
                            state <= (word_cnt == word_total) ? S_ACK : S_RD_REQ;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end

                // ACK/NAK launch their single byte directly so the strobe
                // lands one cycle after the state is entered
                S_ACK: begin
                    if (!tx_busy) begin
                        tx_start     <= 1'b1;
                        tx_data      <= ACK_BYTE;
                        tx_left      <= '0;
                        tx_from_read <= 1'b0;
                        state        <= S_TX_HI;
                    end
                end

                S_NAK: begin
                    if (!tx_busy) begin
                        tx_start     <= 1'b1;
                        tx_data      <= NAK_BYTE;
                        tx_left      <= '0;
                        tx_from_read <= 1'b0;
                        state        <= S_TX_HI;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_mem_loader.sv
module tb_uart_mem_loader;

    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_done = 1'b0;
    logic        tx_busy = 1'b0;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        sel_uart;
    logic        run;
    logic [31:0] w_adress;
    logic [31:0] w_data;
    logic        w_en;
    logic        r_en;
    logic [31:0] r_data = 32'h0;

    always #5 clk = ~clk;

    uart_mem_loader #(
        .ADDR_STEP(1),
        .TIMEOUT_CYCLES(TO),
        .ACK_BYTE(8'h06),
        .NAK_BYTE(8'h15)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_data(rx_data),
        .rx_done(rx_done),
        .tx_busy(tx_busy),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .sel_uart(sel_uart),
        .run(run),
        .w_adress(w_adress),
        .w_data(w_data),
        .w_en(w_en),
        .r_en(r_en),
        .r_data(r_data)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  cmd_q[$];
    logic [7:0]  exp_tx[$];
    logic [63:0] exp_wr[$];
    logic [7:0]  tx_q[$];
    logic [63:0] wr_q[$];
    logic [63:0] wr_hist[$];
    logic [31:0] ref_mem[logic [31:0]];

    int          busy_cnt = 0;
    logic        rd_pend = 1'b0;
    logic [31:0] rd_addr = 32'h0;
    logic [7:0]  last_tx = 8'h00;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // latest value the DUT wrote to an address, 0 if never written
    function automatic logic [31:0] mem_lookup(input logic [31:0] a);
        for (int i = wr_hist.size() - 1; i >= 0; i--) begin
            if (wr_hist[i][63:32] == a) return wr_hist[i][31:0];
        end
        return 32'h0;
    endfunction

    // Memory with one-cycle read latency and a UART transmitter with random busy time
    always @(negedge clk) begin
        if (rst) begin
            check("strobe during reset", {61'h0, w_en, r_en, tx_start}, 64'h0);
        end else begin
            if (rd_pend) begin
                r_data  <= mem_lookup(rd_addr);
                rd_pend <= 1'b0;
            end
            if (w_en || r_en) check("w_en/r_en exclusive", {63'h0, w_en & r_en}, 64'h0);
            if (w_en) begin
                wr_q.push_back({w_adress, w_data});
                wr_hist.push_back({w_adress, w_data});
            end
            if (r_en) begin
                rd_pend <= 1'b1;
                rd_addr <= w_adress;
                r_data  <= 32'hDEADBEEF;
            end
            if (tx_start) begin
                check("tx_start while busy", {63'h0, tx_busy}, 64'h0);
                tx_q.push_back(tx_data);
                last_tx  <= tx_data;
                tx_busy  <= 1'b1;
                busy_cnt <= $urandom_range(2, 6);
            end else if (busy_cnt > 1) begin
                check("tx_data held", {56'h0, tx_data}, {56'h0, last_tx});
                busy_cnt <= busy_cnt - 1;
            end else if (busy_cnt == 1) begin
                busy_cnt <= 0;
                tx_busy  <= 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk); #1;
        rx_done = 1'b0;
    endtask

    task automatic send_range(input int lo, input int hi);
        for (int i = lo; i <= hi && i < cmd_q.size(); i++) begin
            send_byte(cmd_q[i]);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
    endtask

    task automatic push32(input logic [31:0] v);
        for (int i = 0; i < 4; i++) cmd_q.push_back(v[8*i +: 8]);
    endtask

    // Reference: interprets one complete command from cmd_q
    task automatic model_cmd();
        logic [31:0] addr, n, a, word;
        logic [7:0]  c;
        c = cmd_q[0];
        if (c == 8'h57 || c == 8'h52) begin
            addr = {cmd_q[4], cmd_q[3], cmd_q[2], cmd_q[1]};
            n    = {cmd_q[8], cmd_q[7], cmd_q[6], cmd_q[5]};
            for (int i = 0; i < int'(n); i++) begin
                a = addr + 32'(i);
                if (c == 8'h57) begin
                    word = {cmd_q[12+4*i], cmd_q[11+4*i], cmd_q[10+4*i], cmd_q[9+4*i]};
                    ref_mem[a] = word;
                    exp_wr.push_back({a, word});
                end else begin
                    word = ref_mem.exists(a) ? ref_mem[a] : 32'h0;
                    for (int k = 0; k < 4; k++) exp_tx.push_back(word[8*k +: 8]);
                end
            end
            exp_tx.push_back(8'h06);
        end else if (c == 8'h48 || c == 8'h47) begin
            exp_tx.push_back(8'h06);
        end else begin
            exp_tx.push_back(8'h15);
        end
    endtask

    task automatic finish_cmd(input string tag);
        int budget;
        budget = 5000;
        while (tx_q.size() < exp_tx.size() && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        repeat (30) @(posedge clk);
        #1;
        check({tag, " tx count"}, 64'(tx_q.size()), 64'(exp_tx.size()));
        for (int i = 0; i < exp_tx.size() && i < tx_q.size(); i++)
            check({tag, " tx byte"}, {56'h0, tx_q[i]}, {56'h0, exp_tx[i]});
        check({tag, " write count"}, 64'(wr_q.size()), 64'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++)
            check({tag, " write addr/data"}, wr_q[i], exp_wr[i]);
        cmd_q.delete();
        exp_tx.delete();
        exp_wr.delete();
        tx_q.delete();
        wr_q.delete();
    endtask

    task automatic run_cmd(input string tag);
        model_cmd();
        send_range(0, cmd_q.size() - 1);
        finish_cmd(tag);
    endtask

    initial begin
        logic [31:0] a, n;

        // reset values
        repeat (3) @(posedge clk);
        #1;
        check("reset sel_uart", {63'h0, sel_uart}, 64'h1);
        check("reset run", {63'h0, run}, 64'h0);
        check("reset strobes", {61'h0, w_en, r_en, tx_start}, 64'h0);
        check("reset w_adress/w_data", {w_adress, w_data}, 64'h0);
        check("reset tx_data", {56'h0, tx_data}, 64'h0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // 'G': run/sel change the cycle after rx_done, ACK strobe the next
        cmd_q.push_back(8'h47);
        model_cmd();
        send_byte(8'h47);
        check("G run", {63'h0, run}, 64'h1);
        check("G sel_uart", {63'h0, sel_uart}, 64'h0);
        @(posedge clk); #1;
        check("G ack strobe", {55'h0, tx_start, tx_data}, {55'h0, 1'b1, 8'h06});
        finish_cmd("G");

        // 'W' addr 0x10 N=2, w_en right after the 4th data byte
        cmd_q.push_back(8'h57);
        push32(32'h10);
        push32(32'd2);
        push32(32'h44332211);
        push32(32'hDDCCBBAA);
        model_cmd();
        send_range(0, 11);
        send_byte(cmd_q[12]);
        check("W first w_en", {63'h0, w_en}, 64'h1);
        check("W first addr/data", {w_adress, w_data}, {32'h10, 32'h44332211});
        send_range(13, cmd_q.size() - 1);
        finish_cmd("W directed");

        // 'R' addr 0x10 N=2 returns the same bytes then ACK
        cmd_q.push_back(8'h52);
        push32(32'h10);
        push32(32'd2);
        run_cmd("R directed");

        // reset in the middle of a 'W' data phase
        cmd_q.push_back(8'h57);
        push32(32'h20);
        push32(32'd1);
        cmd_q.push_back(8'h01);
        cmd_q.push_back(8'h02);
        send_range(0, cmd_q.size() - 1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("mid reset sel_uart/run", {62'h0, sel_uart, run}, 64'h2);
        check("mid reset w_adress/w_data", {w_adress, w_data}, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cmd_q.delete();
        finish_cmd("mid reset");

        // 'H' after reset gives one ACK
        cmd_q.push_back(8'h48);
        run_cmd("H after reset");

        // 'G' then 'H' toggles run/sel_uart both ways
        cmd_q.push_back(8'h47);
        run_cmd("G toggle");
        check("G toggle run/sel", {62'h0, run, sel_uart}, 64'h2);
        cmd_q.push_back(8'h48);
        run_cmd("H toggle");
        check("H toggle run/sel", {62'h0, run, sel_uart}, 64'h1);

        // unknown command
        cmd_q.push_back(8'h5A);
        run_cmd("unknown");

        // timeout after three address bytes
        cmd_q.push_back(8'h57);
        cmd_q.push_back(8'h01);
        cmd_q.push_back(8'h02);
        cmd_q.push_back(8'h03);
        for (int i = 0; i < 4; i++) send_byte(cmd_q[i]);
        repeat (TO - 10) @(posedge clk);
        #1;
        check("no NAK before timeout", 64'(tx_q.size()), 64'h0);
        exp_tx.push_back(8'h15);
        finish_cmd("timeout");

        // address wrap
        cmd_q.push_back(8'h57);
        push32(32'hFFFFFFFF);
        push32(32'd2);
        push32(32'hCAFEF00D);
        push32(32'h12345678);
        run_cmd("W wrap");

        // N = 0
        cmd_q.push_back(8'h57);
        push32(32'h40);
        push32(32'd0);
        run_cmd("W N=0");
        cmd_q.push_back(8'h52);
        push32(32'h40);
        push32(32'd0);
        run_cmd("R N=0");

        // randomized write/readback against the reference memory
        for (int it = 0; it < 6; it++) begin
            a = 32'h100 + $urandom_range(0, 8);
            n = $urandom_range(1, 4);
            cmd_q.push_back(8'h57);
            push32(a);
            push32(n);
            for (int i = 0; i < int'(n); i++) push32($urandom);
            run_cmd("random W");
            a = 32'h100 + $urandom_range(0, 8);
            n = $urandom_range(1, 4);
            cmd_q.push_back(8'h52);
            push32(a);
            push32(n);
            run_cmd("random R");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_mem_loader.md
# uart_mem_loader

Host-side program loader sitting directly upstream of the MIC-1 SoC's external memory port. It parses a byte-oriented command protocol from the UART receiver and turns it into word writes and reads on the memory manager's external port (`w_adress`/`w_data`/`w_en`/`r_en`/`r_data`). It sends read data and acknowledgements back through the UART transmitter. It also owns the `sel_uart` memory-ownership select and the processor `run` enable, so a host can halt the core, load a program, verify it and start it.

## Interface
- `ADDR_STEP`, 1: address increment per word.
- `TIMEOUT_CYCLES`, 2_000_000: idle cycles allowed between bytes of one command before abort; must be ≥ 1.
- `ACK_BYTE`, 8'h06: byte sent on command success.
- `NAK_BYTE`, 8'h15: byte sent on unknown command or timeout.
- `clk  in  1`: system clock.
- `rst  in  1`: asynchronous reset, active-high.
- `rx_data  in  8`: received byte, valid while `rx_done`.
- `rx_done  in  1`: one-cycle strobe, one per received byte.
- `tx_busy  in  1`: transmitter busy.
- `tx_start  out  1`: one-cycle transmit request.
- `tx_data  out  8`: byte to transmit, held from `tx_start` until `tx_busy` falls.
- `sel_uart  out  1`: 1 = external port owns memory.
- `run  out  1`: processor run enable.
- `w_adress  out  32`: word address for external read/write.
- `w_data  out  32`: write data.
- `w_en  out  1`: one-cycle write strobe.
- `r_en  out  1`: one-cycle read strobe.
- `r_data  in  32`: read data, valid the cycle after `r_en`.

## Operation
- Command byte `0x57` 'W': 4 address bytes, 4 count bytes N, then 4·N data bytes. All multi-byte fields are little-endian. Each completed word is written at `addr + i·ADDR_STEP`; ACK follows the last write.
- Command byte `0x52` 'R': 4 address bytes, 4 count bytes N. For each word: `r_en`, capture `r_data`, transmit its 4 bytes LSB first. ACK follows the last word.
- Command byte `0x48` 'H': `run`←0, `sel_uart`←1, then ACK.
- Command byte `0x47` 'G': `sel_uart`←0, `run`←1, then ACK.
- Any other command byte: NAK, return to IDLE.
- N = 0: send ACK immediately after the count field, with no memory access.
- 'W' and 'R' are accepted regardless of `run`. The host is responsible for sending 'H' first.
- FSM states and transitions:
  - IDLE → HDR on 'W' or 'R'.
  - HDR collects 8 bytes (byte counter 0..7), then → DATA for 'W' or RD_REQ for 'R'.
  - DATA collects 4 bytes into a shift register, then → WRITE.
  - WRITE asserts `w_en` for 1 cycle, then → DATA, or → ACK when the word counter reaches N.
  - RD_REQ → RD_CAP → TX (4 bytes) → RD_REQ, or → ACK.
  - ACK/NAK → TX (1 byte) → IDLE.
- TX per byte: pulse `tx_start` only when `tx_busy`=0. Wait for `tx_busy`=1 and then `tx_busy`=0 before the next byte.
- Timeout: in HDR or DATA, the idle counter reloads on every `rx_done`. Reaching `TIMEOUT_CYCLES` → NAK → IDLE, with the partial word discarded.
- Address arithmetic is 32-bit and wraps modulo 2^32. The word counter is 32-bit.
- `rx_done` arriving in RD_*/TX/ACK states is dropped. The host must wait for ACK before sending the next command.

## Timing
- Reset values:
  - `sel_uart`=1, `run`=0.
  - `w_en`=`r_en`=`tx_start`=0.
  - `w_adress`=`w_data`=0, `tx_data`=0.
  - FSM=IDLE, all counters 0.
- `w_en` is high in the cycle after the `rx_done` of the 4th data byte. `w_adress`/`w_data` are stable in that cycle.
- `r_en` is high for 1 cycle. `r_data` is registered on the next cycle, and the first `tx_start` follows no earlier than 1 cycle later.
- 'G'/'H': `run`/`sel_uart` change in the cycle after the command byte's `rx_done`. The ACK `tx_start` follows in the next cycle if `tx_busy`=0.
- Reset mid-command: return to reset values immediately. No strobe may be emitted after `rst` asserts.
- `w_en` and `r_en` are never both high. `tx_start` is never high while `tx_busy`=1.

## Test plan
- Reset: assert `rst` mid-'W' data → `sel_uart`=1, `run`=0, no `w_en`. A following 'H' produces a single `tx_start` with `tx_data`=0x06.
- 'W', addr 0x10, N=2, data 11 22 33 44 AA BB CC DD → writes 0x44332211 @0x10 and 0xDDCCBBAA @0x11, then ACK 0x06.
- 'R', addr 0x10, N=2 with memory model latency 1 → TX bytes 11 22 33 44 AA BB CC DD 06, with no `tx_start` while `tx_busy`.
- 'G' then 'H' → `run` 0→1, `sel_uart` 1→0, then the reverse; each followed by one ACK.
- Unknown byte 0x5A → NAK 0x15. 'W' + 3 address bytes then silence for `TIMEOUT_CYCLES` (set to 100) → NAK and no `w_en`.
- 'W', addr 0xFFFFFFFF, N=2 → writes @0xFFFFFFFF and @0x00000000. 'W' with N=0 → immediate ACK and no `w_en`.
